// File: rtl/mult4_shift_add_ctrl.sv
// Sequential 4x4 unsigned shift-and-add multiplier that reuses a single sum4 adder.
// Optional MULT4_ZERO_SKIP_EN: zero operands complete on the accepting edge.

module sum4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  assign {c_out, s} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule

module mult4_shift_add_ctrl #(
  parameter bit DONE_PULSE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

`ifdef MULT4_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_r;
  logic [3:0] m_r;
  logic [3:0] q_r;
  logic [3:0] acc_r;
  logic [1:0] cnt_r;

  logic [3:0] sum_s;
  logic       cout_s;
  logic [4:0] add_s;
  logic [3:0] acc_nx_s;
  logic [3:0] q_nx_s;
  logic       zero_op_s;

  sum4 u_sum4 (
    .a     (acc_r),
    .b     (m_r),
    .c_in  (1'b0),
    .s     (sum_s),
    .c_out (cout_s)
  );

  // Conditional add of M into {C,A}, then one right shift of {C,A,Q}; C is folded into add_s[4].
  always_comb begin
    add_s = {1'b0, acc_r};
    if (q_r[0]) begin
      add_s = {cout_s, sum_s};
    end else begin
      add_s = {1'b0, acc_r};
    end
    acc_nx_s  = add_s[4:1];
    q_nx_s    = {add_s[0], q_r[3:1]};
    zero_op_s = ZERO_SKIP && ((a == 4'h0) || (b == 4'h0));
  end

  // Control FSM with registered busy/done/product.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      m_r     <= 4'h0;
      q_r     <= 4'h0;
      acc_r   <= 4'h0;
      cnt_r   <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            m_r   <= a;
            q_r   <= b;
            acc_r <= 4'h0;
            cnt_r <= 2'd0;
            if (zero_op_s) begin
              product <= 8'h00;
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_DONE;
            end else begin
              done    <= 1'b0;
              busy    <= 1'b1;
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r <= acc_nx_s;
          q_r   <= q_nx_s;
          cnt_r <= cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            product <= {acc_nx_s, q_nx_s};
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          // In hold mode done stays set until the next start is accepted in IDLE.
          if (DONE_PULSE) begin
            done <= 1'b0;
          end else begin
            done <= done;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult4_shift_add_ctrl.sv
// Scoreboard bench for mult4_shift_add_ctrl; pulse-mode and hold-mode instances share stimulus.

module tb_mult4_shift_add_ctrl;

`ifdef MULT4_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy_p, done_p, busy_h, done_h;
  logic [7:0] prod_p, prod_h;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_prod;

  always #5 clk = ~clk;

  mult4_shift_add_ctrl #(.DONE_PULSE(1'b1)) dut_p (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_p), .done(done_p), .product(prod_p)
  );

  mult4_shift_add_ctrl #(.DONE_PULSE(1'b0)) dut_h (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy_h), .done(done_h), .product(prod_h)
  );

  // One full transaction; inject=1 pulses a second start (a=2,b=2) during RUN.
  task automatic do_op(input logic [3:0] ai, input logic [3:0] bi, input bit inject);
    int         lat;
    int         exp_lat;
    bit         zero;
    logic [7:0] wide_a;
    logic [7:0] exp_p;
    zero    = ZS && ((ai == 4'h0) || (bi == 4'h0));
    exp_lat = zero ? 0 : 4;
    wide_a  = {4'h0, ai};
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    exp_q.push_back(wide_a * {4'h0, bi});
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done_p !== 1'b1 && lat < 12) begin
      total++;
      if (busy_p !== 1'b1 || busy_h !== 1'b1 || done_h !== 1'b0 || prod_p !== last_prod || prod_h !== last_prod) begin
        bad++;
        $display("FAIL run_state a=%0d b=%0d cyc=%0d busy=%b/%b done_h=%b prod=%h/%h want busy=1 done_h=0 prod=%h",
                 ai, bi, lat, busy_p, busy_h, done_h, prod_p, prod_h, last_prod);
      end
      if (inject && lat == 1) begin
        a = 4'd2; b = 4'd2; start = 1'b1;
      end else if (inject && lat == 2) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    total++;
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL latency a=%0d b=%0d got=%0d want=%0d", ai, bi, lat, exp_lat);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty a=%0d b=%0d", ai, bi);
      exp_p = last_prod;
    end else begin
      exp_p = exp_q.pop_front();
      if (prod_p !== exp_p || prod_h !== exp_p) begin
        bad++;
        $display("FAIL product a=%0d b=%0d got=%h/%h want=%h", ai, bi, prod_p, prod_h, exp_p);
      end
    end
    last_prod = exp_p;
    total++;
    if (done_h !== 1'b1 || busy_p !== 1'b0 || busy_h !== 1'b0) begin
      bad++;
      $display("FAIL done_flags a=%0d b=%0d done_h=%b busy=%b/%b want done_h=1 busy=0",
               ai, bi, done_h, busy_p, busy_h);
    end
    @(negedge clk);
    total++;
    if (done_p !== 1'b0 || done_h !== 1'b1 || busy_p !== 1'b0 || prod_p !== last_prod || prod_h !== last_prod) begin
      bad++;
      $display("FAIL after_done a=%0d b=%0d done=%b/%b busy=%b prod=%h/%h want done=0/1 busy=0 prod=%h",
               ai, bi, done_p, done_h, busy_p, prod_p, prod_h, last_prod);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = 4'h0; b = 4'h0;
    last_prod = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if (busy_p !== 1'b0 || done_p !== 1'b0 || prod_p !== 8'h00 || busy_h !== 1'b0 || done_h !== 1'b0 || prod_h !== 8'h00) begin
      bad++;
      $display("FAIL reset_state busy=%b/%b done=%b/%b prod=%h/%h want all 0",
               busy_p, busy_h, done_p, done_h, prod_p, prod_h);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_op(4'd3, 4'd5, 1'b0);
    do_op(4'd15, 4'd15, 1'b0);
    do_op(4'd15, 4'd1, 1'b0);
    do_op(4'd1, 4'd15, 1'b0);
  endtask

  task automatic test_ignore_start();
    do_op(4'd9, 4'd7, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (busy_p !== 1'b0 || done_p !== 1'b0 || prod_p !== 8'h3F) begin
        bad++;
        $display("FAIL no_second_run cyc=%0d busy=%b done=%b prod=%h want 0 0 3f", i, busy_p, done_p, prod_p);
      end
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    a = 4'd12; b = 4'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_prod = 8'h00;
    total++;
    if (busy_p !== 1'b0 || done_p !== 1'b0 || done_h !== 1'b0 || prod_p !== 8'h00 || prod_h !== 8'h00) begin
      bad++;
      $display("FAIL abort_state busy=%b done=%b/%b prod=%h/%h want 0", busy_p, done_p, done_h, prod_p, prod_h);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (done_p !== 1'b0 || busy_p !== 1'b0 || prod_p !== 8'h00) begin
        bad++;
        $display("FAIL abort_quiet cyc=%0d done=%b busy=%b prod=%h want 0", i, done_p, busy_p, prod_p);
      end
    end
  endtask

  task automatic test_zero();
    do_op(4'd0, 4'd9, 1'b0);
    do_op(4'd7, 4'd0, 1'b0);
  endtask

  task automatic test_done_hold();
    do_op(4'd6, 4'd7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (done_h !== 1'b1 || prod_h !== 8'h2A || done_p !== 1'b0) begin
        bad++;
        $display("FAIL done_hold cyc=%0d done_h=%b prod_h=%h done_p=%b want 1 2a 0", i, done_h, prod_h, done_p);
      end
    end
    do_op(4'd1, 4'd1, 1'b0);
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        do_op(4'(i), 4'(j), 1'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_abort();
    test_zero();
    test_done_hold();
    test_sweep();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
